gate_exerciser: RTL and testbench



---
 rtl/gate_lab_pkg.sv | 29 ++
 rtl/gate_exerciser_if.sv | 27 ++
 rtl/gate_exerciser_settle_timer.sv | 31 +++
 rtl/gate_exerciser.sv | 116 +++++++++++
 tb/tb_gate_exerciser.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/gate_lab_pkg.sv
// Shared definitions for the gate lab: FSM encoding, result payload and truth tables.
package gate_lab_pkg;

    localparam int unsigned VEC_W   = 2;
    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ERR_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Result registers reported back to the lab controller.
    typedef struct packed {
        logic               pass;
        logic [ERR_W-1:0]   err_cnt;
        logic [NUM_VEC-1:0] fail_mask;
    } result_t;

    // Bit k is the expected gate output for input vector {A,B}=k.
    localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
    localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
    localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
    localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
    localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_exerciser_if.sv
// Signals between the exerciser and the gate under test / run controller.
interface gate_exerciser_if;
    import gate_lab_pkg::*;

    logic               START;
    logic               O;
    logic               A;
    logic               B;
    logic               BUSY;
    logic               DONE;
    logic               PASS;
    logic [ERR_W-1:0]   ERR_CNT;
    logic [NUM_VEC-1:0] FAIL_MASK;

    // Exerciser side: drives the gate inputs and results.
    modport master (
        input  START, O,
        output A, B, BUSY, DONE, PASS, ERR_CNT, FAIL_MASK
    );

    // Gate / controller side.
    modport slave (
        output START, O,
        input  A, B, BUSY, DONE, PASS, ERR_CNT, FAIL_MASK
    );

endinterface

// File: rtl/gate_exerciser_settle_timer.sv
// 8-bit up/down counter with load; flags when the count reaches the terminal value.
module settle_timer
    import gate_lab_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] term,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: load has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= up ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
        end
    end

    // Terminal count is a same-cycle decode of the register.
    assign tc_c = (cnt_q == term);

endmodule

// File: rtl/gate_exerciser.sv
// Walks a two-input gate through all four input vectors, samples its output
// after a settle time and reports pass/fail, an error count and a failure mask.
module gate_exerciser
    import gate_lab_pkg::*;
#(
    parameter int unsigned        SETTLE_CYCLES = 4,
    parameter logic [NUM_VEC-1:0] EXPECT        = TT_NAND
) (
    input  logic            CLK,
    input  logic            RST_N,
    gate_exerciser_if.master bus
);

    localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    result_t          res_q, res_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic             tmr_en;
    logic             settle_tc_c;

    // Settle counter restarts at every new vector and flags the sample edge.
    settle_timer u_settle_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (tmr_load),
        .en       (tmr_en),
        .up       (1'b1),
        .load_val ('0),
        .term     (SETTLE_TERM),
        .tc_c     (settle_tc_c)
    );

    // State, vector index, results and output flops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            res_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, result update and next-output decode.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        res_d    = res_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d  = ST_RUN;
                    vec_d    = '0;
                    res_d    = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_RUN: begin
                tmr_en = 1'b1;
                if (settle_tc_c) begin
                    if (bus.O != EXPECT[vec_q]) begin
                        res_d.fail_mask[vec_q] = 1'b1;
                        res_d.err_cnt          = res_q.err_cnt + ERR_W'(1);
                    end
                    if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                        state_d = ST_REPORT;
                    end else begin
                        vec_d    = vec_q + VEC_W'(1);
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_REPORT: begin
                res_d.pass = (res_q.err_cnt == '0);
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        busy_d     = (state_d == ST_RUN);
        done_d     = (state_d == ST_REPORT);
        {a_d, b_d} = busy_d ? vec_d : 2'b00;
    end

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.PASS      = res_q.pass;
    assign bus.ERR_CNT   = res_q.err_cnt;
    assign bus.FAIL_MASK = res_q.fail_mask;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: three instances (S=4 NAND, S=4 AND, S=1 NAND),
// each driving a modelled gate whose truth table is set per run.
module tb_gate_exerciser;
    import gate_lab_pkg::*;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;

    logic [2:0] start_r;
    logic [3:0] tt_r [3];

    gate_exerciser_if g0();
    gate_exerciser_if g1();
    gate_exerciser_if g2();

    assign g0.START = start_r[0];
    assign g1.START = start_r[1];
    assign g2.START = start_r[2];
    assign g0.O     = tt_r[0][{g0.A, g0.B}];
    assign g1.O     = tt_r[1][{g1.A, g1.B}];
    assign g2.O     = tt_r[2][{g2.A, g2.B}];

    gate_exerciser #(.SETTLE_CYCLES(4), .EXPECT(TT_NAND)) u_nand4 (.CLK(CLK), .RST_N(RST_N), .bus(g0));
    gate_exerciser #(.SETTLE_CYCLES(4), .EXPECT(TT_AND))  u_and4  (.CLK(CLK), .RST_N(RST_N), .bus(g1));
    gate_exerciser #(.SETTLE_CYCLES(1), .EXPECT(TT_NAND)) u_nand1 (.CLK(CLK), .RST_N(RST_N), .bus(g2));

    logic [2:0]       busy_w, done_w, pass_w, a_w, b_w;
    logic [2:0][2:0]  err_w;
    logic [2:0][3:0]  mask_w;

    assign busy_w = {g2.BUSY, g1.BUSY, g0.BUSY};
    assign done_w = {g2.DONE, g1.DONE, g0.DONE};
    assign pass_w = {g2.PASS, g1.PASS, g0.PASS};
    assign a_w    = {g2.A, g1.A, g0.A};
    assign b_w    = {g2.B, g1.B, g0.B};
    assign err_w  = {g2.ERR_CNT, g1.ERR_CNT, g0.ERR_CNT};
    assign mask_w = {g2.FAIL_MASK, g1.FAIL_MASK, g0.FAIL_MASK};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int s_of(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic logic [3:0] exp_of(input int d);
        return (d == 1) ? 4'b1000 : 4'b0111;
    endfunction

    function automatic int pop4(input logic [3:0] m);
        int n = 0;
        for (int i = 0; i < 4; i++) if (m[i]) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // One full run on instance d, checking every cycle against the timing rules.
    task automatic run(input int d, input logic [3:0] tt, input bit extra,
                       input int exp_err, input logic [3:0] exp_mask, input bit exp_pass);
        int s;
        s = s_of(d);
        tt_r[d] = tt;
        @(negedge CLK);
        start_r[d] = 1'b1;
        for (int t = 0; t < 4 * s; t++) begin
            @(negedge CLK);
            start_r[d] = extra && (t == 1);
            chk("busy_run", 32'(busy_w[d]), 32'd1);
            chk("ab_step", 32'({a_w[d], b_w[d]}), 32'(t / s));
            chk("done_low", 32'(done_w[d]), 32'd0);
            if (t < s) begin
                chk("clr_err", 32'(err_w[d]), 32'd0);
                chk("clr_mask", 32'(mask_w[d]), 32'd0);
                chk("clr_pass", 32'(pass_w[d]), 32'd0);
            end
        end
        @(negedge CLK);
        start_r[d] = extra;
        chk("busy_end", 32'(busy_w[d]), 32'd0);
        chk("done_pulse", 32'(done_w[d]), 32'd1);
        chk("ab_idle", 32'({a_w[d], b_w[d]}), 32'd0);
        chk("err_cnt", 32'(err_w[d]), 32'(exp_err));
        chk("fail_mask", 32'(mask_w[d]), 32'(exp_mask));
        chk("pass_early", 32'(pass_w[d]), 32'd0);
        @(negedge CLK);
        start_r[d] = 1'b0;
        chk("done_one", 32'(done_w[d]), 32'd0);
        chk("pass", 32'(pass_w[d]), 32'(exp_pass));
        chk("err_hold", 32'(err_w[d]), 32'(exp_err));
        @(negedge CLK);
        chk("idle_hold", 32'(busy_w[d]), 32'd0);
        chk("pass_hold", 32'(pass_w[d]), 32'(exp_pass));
        chk("mask_hold", 32'(mask_w[d]), 32'(exp_mask));
    endtask

    typedef struct {
        int         d;
        logic [3:0] tt;
        bit         extra;
        int         exp_err;
        logic [3:0] exp_mask;
        bit         exp_pass;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int         d;
        logic [3:0] tt;
        logic [3:0] m;

        checks   = 0;
        failures = 0;
        RST_N    = 1'b0;
        start_r  = '0;
        for (int i = 0; i < 3; i++) tt_r[i] = 4'b0111;

        tbl[0] = '{0, 4'b0111, 1'b0, 0, 4'b0000, 1'b1};   // correct NAND
        tbl[1] = '{0, 4'b1111, 1'b0, 1, 4'b1000, 1'b0};   // O stuck at 1
        tbl[2] = '{0, 4'b0000, 1'b0, 3, 4'b0111, 1'b0};   // O stuck at 0
        tbl[3] = '{1, 4'b0111, 1'b0, 4, 4'b1111, 1'b0};   // NAND vs AND table
        tbl[4] = '{1, 4'b0111, 1'b1, 4, 4'b1111, 1'b0};   // again, stray STARTs
        tbl[5] = '{2, 4'b0111, 1'b0, 0, 4'b0000, 1'b1};   // S=1 NAND
        tbl[6] = '{0, 4'b0110, 1'b0, 1, 4'b0001, 1'b0};   // XOR gate on NAND table

        repeat (3) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 32'(busy_w[i]), 32'd0);
            chk("rst_done", 32'(done_w[i]), 32'd0);
            chk("rst_pass", 32'(pass_w[i]), 32'd0);
            chk("rst_err", 32'(err_w[i]), 32'd0);
            chk("rst_mask", 32'(mask_w[i]), 32'd0);
            chk("rst_ab", 32'({a_w[i], b_w[i]}), 32'd0);
        end
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 7; i++) begin
            run(tbl[i].d, tbl[i].tt, tbl[i].extra, tbl[i].exp_err, tbl[i].exp_mask, tbl[i].exp_pass);
        end

        // Reset in the middle of vector 2 (cycle 10 of the run).
        tt_r[0] = 4'b0000;
        @(negedge CLK);
        start_r[0] = 1'b1;
        @(negedge CLK);
        start_r[0] = 1'b0;
        repeat (10) @(negedge CLK);
        chk("pre_rst_err", 32'(err_w[0]), 32'd2);
        chk("pre_rst_mask", 32'(mask_w[0]), 32'h3);
        chk("pre_rst_ab", 32'({a_w[0], b_w[0]}), 32'd2);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        chk("mid_rst_ab", 32'({a_w[0], b_w[0]}), 32'd0);
        chk("mid_rst_err", 32'(err_w[0]), 32'd0);
        chk("mid_rst_mask", 32'(mask_w[0]), 32'd0);
        chk("mid_rst_pass", 32'(pass_w[0]), 32'd0);
        chk("mid_rst_done", 32'(done_w[0]), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run(0, 4'b0111, 1'b0, 0, 4'b0000, 1'b1);

        // Random gates: expected results follow directly from XOR with the table.
        for (int r = 0; r < 10; r++) begin
            d  = int'($urandom_range(0, 2));
            tt = 4'($urandom);
            m  = tt ^ exp_of(d);
            run(d, tt, 1'($urandom_range(0, 1)), pop4(m), m, (m == 4'b0000));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
